// File: rtl/dsp_result_pkg.sv
// Shared widths, saturation constant and the round/scale/saturate helper for the DSP result sink.
package dsp_result_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IN_W   = 2 * DATA_W;
    localparam int unsigned DROP_W = 16;
    localparam logic [DATA_W-1:0] SAT_MAX = '1;

    // Round-half-up right shift at IN_W+1 bits; returns {sat_flag, value}.
    function automatic logic [DATA_W:0] round_sat(input logic [IN_W-1:0] x,
                                                  input int unsigned shift);
        logic [IN_W:0] bias;
        logic [IN_W:0] sum;
        logic [IN_W:0] r;
        bias = (shift == 0) ? '0 : ((IN_W+1)'(1) << (shift - 1));
        sum  = {1'b0, x} + bias;
        r    = sum >> shift;
        if (r > (IN_W+1)'(SAT_MAX)) begin
            return {1'b1, SAT_MAX};
        end
        return {1'b0, r[DATA_W-1:0]};
    endfunction

endpackage

// File: rtl/dsp_result_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous push and pop allowed when full.
module dsp_result_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push_c;
    logic                  do_pop_c;

    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dsp_result_sink.sv
// DSP result sink: round/saturate stage, FIFO, sticky flags and drop counter.
// Optional decimation of incoming results is enabled by defining DSP_RESULT_DECIM_EN.
module dsp_result_sink
    import dsp_result_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_W,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned SHIFT        = 8,
    parameter int unsigned DECIM_FACTOR = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*DATA_WIDTH-1:0]       in_data,
    input  logic                          in_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          sat_seen,
    output logic [DROP_W-1:0]             drop_count,
    input  logic                          clear_flags
);

    logic                  accept_c;
    logic [DATA_W:0]       rs_c;
    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push_c;
    logic                  pop_c;
    logic                  drop_c;
    logic                  sat_event_c;

`ifdef DSP_RESULT_DECIM_EN
    localparam int unsigned PH_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    logic [PH_W-1:0] phase;

    // Only the phase-0 result of each group of DECIM_FACTOR is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase == PH_W'(DECIM_FACTOR - 1)) ? '0 : phase + PH_W'(1);
        end
    end

    assign accept_c = in_valid && (phase == '0);
`else
    assign accept_c = in_valid && (DECIM_FACTOR >= 1);
`endif

    assign rs_c        = round_sat(IN_W'(in_data), SHIFT);
    assign sat_event_c = accept_c && rs_c[DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            stage_valid <= accept_c;
            if (accept_c) stage_data <= DATA_WIDTH'(rs_c[DATA_W-1:0]);
        end
    end

    assign out_valid = !fifo_empty;
    assign pop_c     = out_valid && out_ready;
    assign push_c    = stage_valid && (!fifo_full || pop_c);
    assign drop_c    = stage_valid && fifo_full && !pop_c;

    dsp_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .wr_data (stage_data),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fill_level)
    );

    // Sticky status; a new event in the clearing cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            sat_seen   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (sat_event_c)      sat_seen <= 1'b1;
            else if (clear_flags) sat_seen <= 1'b0;

            if (drop_c) begin
                overflow <= 1'b1;
                if (clear_flags)              drop_count <= DROP_W'(1);
                else if (drop_count != '1)    drop_count <= drop_count + DROP_W'(1);
            end else if (clear_flags) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_result_sink.sv
// Self-checking bench for dsp_result_sink against a queue-based behavioural model.
// Decimation scenario runs only when DSP_RESULT_DECIM_EN is defined.
module tb_dsp_result_sink;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SH    = 8;
    localparam int unsigned DF    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   in_data;
    logic          in_valid;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fill_level;
    logic          overflow;
    logic          sat_seen;
    logic [15:0]   drop_count;
    logic          clear_flags;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int  mq[$];
    bit  stg_v;
    int  stg_d;
    bit  m_ovf;
    bit  m_sat;
    int  m_drop;
    int  m_ph;

    always #5 clk = ~clk;

    dsp_result_sink #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .SHIFT        (SH),
        .DECIM_FACTOR (DF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_level  (fill_level),
        .overflow    (overflow),
        .sat_seen    (sat_seen),
        .drop_count  (drop_count),
        .clear_flags (clear_flags)
    );

    function automatic int scale(input logic [31:0] d, output bit sat);
        longint r;
        r = (longint'(d) + (longint'(1) << (SH - 1))) / (longint'(1) << SH);
        sat = (r > 65535);
        return sat ? 65535 : int'(r);
    endfunction

    task automatic model_clear();
        mq.delete();
        stg_v = 0; stg_d = 0; m_ovf = 0; m_sat = 0; m_drop = 0; m_ph = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle 1ns after.
    task automatic tick(input bit v, input logic [31:0] d, input bit rdy, input bit clr);
        bit pop, full, drop, sat, acc;
        int val;
        in_valid = v; in_data = d; out_ready = rdy; clear_flags = clr; rst = 0;
        @(posedge clk);
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH);
        drop = 0;
        if (pop) void'(mq.pop_front());
        if (stg_v) begin
            if (full && !pop) drop = 1;
            else mq.push_back(stg_d);
        end
`ifdef DSP_RESULT_DECIM_EN
        acc = v && (m_ph == 0);
        if (v) m_ph = (m_ph + 1) % DF;
`else
        acc = v;
`endif
        sat = 0;
        val = scale(d, sat);
        stg_v = acc;
        if (acc) stg_d = val;
        if (acc && sat) m_sat = 1; else if (clr) m_sat = 0;
        if (drop) begin
            m_ovf = 1;
            m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
        end else if (clr) begin
            m_ovf = 0; m_drop = 0;
        end
        #1;
    endtask

    task automatic apply_reset(input bit v);
        in_valid = v; in_data = 32'h0000_0300; out_ready = 0; clear_flags = 0; rst = 1;
        @(posedge clk);
        model_clear();
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset(0);
        if (out_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b0 ||
            sat_seen !== 1'b0 || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL reset: valid=%b lvl=%0d ovf=%b sat=%b drops=%0d, want all zero",
                     out_valid, fill_level, overflow, sat_seen, drop_count);
        end
        total++;
    endtask

    task automatic test_latency();
        tick(1, 32'h0000_1280, 1, 0);
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL latency_early: out_valid=%b want 0", out_valid);
        end
        total++;
        tick(0, 32'h0, 1, 0);
        if (out_valid !== 1'b1 || out_data !== 16'h0013) begin
            bad++; $display("FAIL latency_data: valid=%b data=%h want 1/0013", out_valid, out_data);
        end
        total++;
        tick(0, 32'h0, 1, 0);
    endtask

    task automatic test_saturation();
        tick(1, 32'h0100_0000, 1, 0);
        tick(0, 32'h0, 1, 0);
        if (out_data !== 16'hFFFF || sat_seen !== 1'b1) begin
            bad++; $display("FAIL sat_value: data=%h sat=%b want ffff/1", out_data, sat_seen);
        end
        total++;
        tick(0, 32'h0, 1, 1);
        if (sat_seen !== 1'b0) begin
            bad++; $display("FAIL sat_clear: sat=%b want 0", sat_seen);
        end
        total++;
        // saturation in the same cycle as clear_flags keeps the flag set
        tick(1, 32'hFFFF_FFFF, 1, 1);
        if (sat_seen !== 1'b1) begin
            bad++; $display("FAIL sat_vs_clear: sat=%b want 1", sat_seen);
        end
        total++;
        tick(0, 32'h0, 1, 1);
        tick(0, 32'h0, 1, 0);
    endtask

    task automatic test_overflow();
        apply_reset(0);
        for (int i = 1; i <= 9; i++) tick(1, 32'(i) << 8, 0, 0);
        tick(0, 32'h0, 0, 0);
        if (fill_level !== 4'd8 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            bad++;
            $display("FAIL overflow: lvl=%0d ovf=%b drops=%0d want 8/1/1",
                     fill_level, overflow, drop_count);
        end
        total++;
        for (int i = 1; i <= 8; i++) begin
            if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
                bad++; $display("FAIL drain_%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, 16'(i));
            end
            total++;
            tick(0, 32'h0, 1, 0);
        end
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL drain_empty: out_valid=%b want 0", out_valid);
        end
        total++;
        // drop in the clearing cycle: counter restarts at 1
        for (int i = 1; i <= 9; i++) tick(1, 32'(i) << 8, 0, 0);
        tick(1, 32'h0, 0, 0);
        tick(0, 32'h0, 0, 1);
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            bad++; $display("FAIL drop_vs_clear: ovf=%b drops=%0d want 1/1", overflow, drop_count);
        end
        total++;
    endtask

    task automatic test_full_push_pop();
        apply_reset(0);
        for (int i = 1; i <= 9; i++) tick(1, 32'(i) << 8, 0, 0);
        tick(0, 32'h0, 1, 0);
        if (fill_level !== 4'd8 || drop_count !== 16'd0 || out_data !== 16'd2) begin
            bad++;
            $display("FAIL full_push_pop: lvl=%0d drops=%0d head=%h want 8/0/0002",
                     fill_level, drop_count, out_data);
        end
        total++;
        for (int i = 2; i <= 9; i++) begin
            if (out_data !== 16'(i)) begin
                bad++; $display("FAIL full_order_%0d: data=%h want %h", i, out_data, 16'(i));
            end
            total++;
            tick(0, 32'h0, 1, 0);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(0);
        for (int i = 1; i <= 5; i++) tick(1, 32'(i) << 8, 0, 0);
        tick(0, 32'h0, 0, 0);
        if (fill_level !== 4'd5) begin
            bad++; $display("FAIL pre_reset_level: lvl=%0d want 5", fill_level);
        end
        total++;
        apply_reset(1);
        if (out_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b lvl=%0d ovf=%b want 0/0/0", out_valid, fill_level, overflow);
        end
        total++;
        tick(1, 32'h0000_0500, 1, 0);
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_early: valid=%b want 0", out_valid);
        end
        total++;
        tick(0, 32'h0, 1, 0);
        if (out_valid !== 1'b1 || out_data !== 16'h0005) begin
            bad++; $display("FAIL post_reset_data: valid=%b data=%h want 1/0005", out_valid, out_data);
        end
        total++;
        tick(0, 32'h0, 1, 0);
    endtask

    task automatic test_random();
        logic [31:0] d;
        apply_reset(0);
        for (int c = 0; c < 400; c++) begin
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d = d & 32'h00FF_FFFF;
            tick(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 19) == 0));
            if (out_valid !== (mq.size() != 0) || fill_level !== 4'(mq.size())) begin
                bad++;
                $display("FAIL rand_level c=%0d: valid=%b lvl=%0d want %b/%0d",
                         c, out_valid, fill_level, (mq.size() != 0), mq.size());
            end
            total++;
            if (mq.size() != 0) begin
                if (out_data !== 16'(mq[0])) begin
                    bad++; $display("FAIL rand_data c=%0d: data=%h want %h", c, out_data, 16'(mq[0]));
                end
                total++;
            end
            if (overflow !== m_ovf || sat_seen !== m_sat || drop_count !== 16'(m_drop)) begin
                bad++;
                $display("FAIL rand_flags c=%0d: ovf=%b sat=%b drops=%0d want %b/%b/%0d",
                         c, overflow, sat_seen, drop_count, m_ovf, m_sat, m_drop);
            end
            total++;
        end
    endtask

`ifdef DSP_RESULT_DECIM_EN
    task automatic test_decim();
        int got[$];
        apply_reset(0);
        for (int i = 1; i <= 12; i++) begin
            if (out_valid) got.push_back(int'(out_data));
            tick((i <= 8), 32'(i) << 8, 1, 0);
        end
        if (got.size() != 2 || got[0] != 1 || got[1] != 5) begin
            bad++; $display("FAIL decim: count=%0d want 2 outputs 0001,0005", got.size());
        end
        total++;
    endtask
`endif

    initial begin
        rst = 1; in_valid = 0; in_data = 0; out_ready = 0; clear_flags = 0;
        model_clear();
        test_reset();
`ifdef DSP_RESULT_DECIM_EN
        test_decim();
`else
        test_latency();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
